ripple_counter_2bit: RTL and testbench



---
 rtl/ripple_counter_2bit.sv | 40 ++++
 tb/tb_ripple_counter_2bit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ripple_counter_2bit.sv
// Asynchronous ripple up-counter: stage 0 toggles on clk, each higher stage
// toggles on the falling edge of the stage below. Async active-high reset.
module ripple_counter_2bit #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_clk;
    logic tff_q;
    logic tff_d;

    // Higher stages clock on the rising edge of the inverted lower stage.
    if (i == 0) begin : g_first
      assign stage_clk = clk;
    end else begin : g_chain
      assign stage_clk = ~count[i-1];
    end

    assign tff_d = ~tff_q;

    always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) begin
        tff_q <= 1'b0;
      end else begin
        tff_q <= tff_d;
      end
    end

    assign count[i] = tff_q;
  end

  assign q = count;

endmodule

// File: tb/tb_ripple_counter_2bit.sv
// Self-checking bench for ripple_counter_2bit: default and 4-bit instances
// against an edge-count model, directed plan steps then randomized resets.
module tb_ripple_counter_2bit;

  logic       clk;
  logic       reset;
  logic [1:0] q2;
  logic [3:0] q4;

  int unsigned asserts_cnt;
  int unsigned fail_cnt;
  int unsigned n;        // model: rising clk edges counted since last release
  bit          rst_on;   // model view of reset level

  time q0_last_rise, q0_period, q0_high;
  time q1_last_rise, q1_period, q1_high;

  ripple_counter_2bit dut2 (
    .clk   (clk),
    .reset (reset),
    .q     (q2)
  );

  ripple_counter_2bit #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .q     (q4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge q2[0]) begin
    q0_period    = $time - q0_last_rise;
    q0_last_rise = $time;
  end
  always @(negedge q2[0]) q0_high = $time - q0_last_rise;
  always @(posedge q2[1]) begin
    q1_period    = $time - q1_last_rise;
    q1_last_rise = $time;
  end
  always @(negedge q2[1]) q1_high = $time - q1_last_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_w2"}, {30'd0, q2}, n % 4);
    check({tag, "_w4"}, {28'd0, q4}, n % 16);
  endtask

  task automatic advance(input int unsigned k);
    repeat (k) begin
      @(posedge clk);
      if (!rst_on) n++;
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    check_both(tag);
  endtask

  initial begin
    asserts_cnt  = 0;
    fail_cnt     = 0;
    n            = 0;
    q0_last_rise = 0; q0_period = 0; q0_high = 0;
    q1_last_rise = 0; q1_period = 0; q1_high = 0;
    reset  = 1'b1;
    rst_on = 1'b1;

    // Power-up reset held across 77 rising edges.
    repeat (77) sample("por_hold");
    #7;
    reset  = 1'b0;
    rst_on = 1'b0;

    // First edges after release, including wrap of the 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      advance(1);
      sample("release_walk");
    end
    check("walk_wrap_w2", {30'd0, q2}, 32'd0);

    // Free-run to 73 counted edges.
    while (n < 73) begin
      advance(1);
      sample("free_run");
    end
    check("q_at_3000", {30'd0, q2}, 32'd1);
    check("q0_period", q0_period[31:0], 32'd40);
    check("q0_high",   q0_high[31:0],   32'd20);
    check("q1_period", q1_period[31:0], 32'd80);
    check("q1_high",   q1_high[31:0],   32'd40);

    // Asynchronous reset mid-count with q == 3.
    while (n % 4 != 3) begin
      advance(1);
      sample("seek3");
    end
    advance(1);
    while (n % 4 != 3) advance(1);
    #5;
    reset  = 1'b1;
    rst_on = 1'b1;
    n      = 0;
    #1;
    check_both("async_clear");
    for (int i = 0; i < 3; i++) begin
      advance(1);
      sample("reset_hold");
    end

    // Release coincident with a rising edge: flop must still see reset there.
    @(posedge clk);
    reset <= 1'b0;
    rst_on = 1'b0;
    sample("coincident_release");
    for (int i = 0; i < 17; i++) begin
      advance(1);
      sample("walk16");
    end

    // Randomized run lengths with asynchronous reset pulses off the clock edge.
    for (int r = 0; r < 20; r++) begin
      int unsigned k;
      k = $urandom_range(24, 1);
      repeat (k) begin
        advance(1);
        sample("rand_run");
      end
      if ($urandom_range(1, 0) == 1) begin
        int unsigned h;
        @(posedge clk);
        if (!rst_on) n++;
        #($urandom_range(8, 1));
        reset  = 1'b1;
        rst_on = 1'b1;
        n      = 0;
        #1;
        check_both("rand_async_clear");
        h = $urandom_range(3, 0);
        repeat (h) begin
          advance(1);
          sample("rand_hold");
        end
        @(posedge clk);
        #($urandom_range(18, 2));
        reset  = 1'b0;
        rst_on = 1'b0;
      end
    end
    advance(1);
    sample("final");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
    $finish;
  end

endmodule
